// File: rtl/snn_syn_pkg.sv
// Shared types and arithmetic helpers for the synaptic current accumulator.
package snn_syn_pkg;

  typedef enum logic [1:0] {
    CLR   = 2'd0,
    ACC   = 2'd1,
    FLUSH = 2'd2,
    DRAIN = 2'd3
  } acc_state_e;

  typedef struct packed {
    logic [63:0] sum;  // clamped result, two's complement, sign-extended
    logic        sat;  // clamp was applied
  } sat_res_t;

  // Add two sign-extended operands and clamp to a signed acc_w-bit range.
  // Operands are carried at 64 bits so one helper serves any accumulator width < 64.
  function automatic sat_res_t sat_add(input logic signed [63:0] acc,
                                       input logic signed [63:0] w,
                                       input int unsigned        acc_w);
    sat_res_t           res;
    logic signed [63:0] acc_max;
    logic signed [63:0] acc_min;
    logic signed [63:0] raw;
    acc_max = (64'sd1 <<< (acc_w - 1)) - 64'sd1;
    acc_min = -(64'sd1 <<< (acc_w - 1));
    raw     = acc + w;
    res.sat = 1'b0;
    res.sum = raw;
    if (raw > acc_max) begin
      res.sum = acc_max;
      res.sat = 1'b1;
    end else if (raw < acc_min) begin
      res.sum = acc_min;
      res.sat = 1'b1;
    end
    return res;
  endfunction

endpackage

// File: rtl/acc_ram_1r1w.sv
// Accumulator storage: one synchronous read port, one write port.
// Read returns the pre-write contents on a same-address collision; the parent forwards.
module acc_ram_1r1w #(
  parameter int unsigned Depth = 64,
  parameter int unsigned Width = 24,
  parameter int unsigned AddrW = 6
) (
  input  logic             clk_i,
  input  logic             re_i,
  input  logic [AddrW-1:0] raddr_i,
  output logic [Width-1:0] rdata_o,
  input  logic             we_i,
  input  logic [AddrW-1:0] waddr_i,
  input  logic [Width-1:0] wdata_i
);

  logic [Width-1:0] mem [Depth];

  // Registered read and write; read data only moves when a read is requested.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_o <= mem[raddr_i];
    end
  end

endmodule

// File: rtl/synaptic_current_accumulator.sv
// Per-neuron saturating current accumulator with a timestep drain to the neuron-update stage.
module synaptic_current_accumulator
  import snn_syn_pkg::*;
#(
  parameter int unsigned N_NEURON                = 64,
  parameter int unsigned NEURON_ID_W             = (N_NEURON > 1) ? $clog2(N_NEURON) : 1,
  parameter int unsigned WEIGHT_W                = 16,
  parameter int unsigned ACC_W                   = 24,
  parameter bit          ACCUMULATE_ON_COLLISION = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clk_en,
  input  logic                   syn_in_valid,
  output logic                   syn_in_ready,
  input  logic [NEURON_ID_W-1:0] syn_dst_id_i,
  input  logic [WEIGHT_W-1:0]    syn_weight_i,
  input  logic                   tick_i,
  output logic                   drain_valid_o,
  input  logic                   drain_ready_i,
  output logic [NEURON_ID_W-1:0] drain_id_o,
  output logic [ACC_W-1:0]       drain_cur_o,
  output logic                   drain_last_o,
  output logic                   busy_o,
  output logic [15:0]            sat_cnt_o
);

  localparam logic [NEURON_ID_W-1:0] LastId = NEURON_ID_W'(N_NEURON - 1);

  acc_state_e             state_q, state_d;
  logic [NEURON_ID_W-1:0] idx_q, idx_d;
  logic                   tick_pend_q, tick_pend_d;

  // S1: event whose RAM read is returning this cycle. S2: last value written by S1.
  logic                   s1_valid_q;
  logic [NEURON_ID_W-1:0] s1_id_q;
  logic [WEIGHT_W-1:0]    s1_w_q;
  logic                   s2_valid_q;
  logic [NEURON_ID_W-1:0] s2_id_q;
  logic [ACC_W-1:0]       s2_val_q;

  logic                   rd_pend_q;
  logic                   out_valid_q;
  logic [NEURON_ID_W-1:0] out_id_q;
  logic [ACC_W-1:0]       out_cur_q;
  logic                   out_last_q;
  logic [15:0]            sat_cnt_q;

  logic                   syn_accept;
  logic                   drain_hs;
  logic                   drain_issue;
  logic [ACC_W-1:0]       old_val;
  logic [ACC_W-1:0]       wr_val;
  logic                   wr_sat;
  sat_res_t               sum_res;
  logic                   unused_sum_hi;

  logic                   ram_re;
  logic [NEURON_ID_W-1:0] ram_raddr;
  logic [ACC_W-1:0]       ram_rdata;
  logic                   ram_we;
  logic [NEURON_ID_W-1:0] ram_waddr;
  logic [ACC_W-1:0]       ram_wdata;

  assign syn_in_ready = clk_en & ~tick_pend_q & (state_q == ACC);
  assign syn_accept   = syn_in_valid & syn_in_ready;
  assign drain_hs     = clk_en & out_valid_q & drain_ready_i;
  // Fetch the first entry on DRAIN entry, then prefetch the next one on each handshake.
  assign drain_issue  = (state_q == DRAIN) &&
                        ((!out_valid_q && !rd_pend_q) || (drain_hs && !out_last_q));

  // S1 read-modify: forward the entry S2 just wrote, since the RAM read predates it.
  always_comb begin
    old_val = (s2_valid_q && (s2_id_q == s1_id_q)) ? s2_val_q : ram_rdata;
    sum_res = sat_add({{(64 - ACC_W){old_val[ACC_W-1]}}, old_val},
                      {{(64 - WEIGHT_W){s1_w_q[WEIGHT_W-1]}}, s1_w_q}, ACC_W);
    if (ACCUMULATE_ON_COLLISION) begin
      wr_val = sum_res.sum[ACC_W-1:0];
      wr_sat = sum_res.sat;
    end else begin
      wr_val = {{(ACC_W - WEIGHT_W){s1_w_q[WEIGHT_W-1]}}, s1_w_q};
      wr_sat = 1'b0;
    end
  end

  assign unused_sum_hi = ^sum_res.sum[63:ACC_W];

  // RAM port steering: clear sweep, drain zeroing and S1 write-back never overlap.
  always_comb begin
    ram_re    = clk_en & (syn_accept | drain_issue);
    ram_raddr = (state_q == DRAIN) ? (drain_hs ? idx_q + 1'b1 : idx_q) : syn_dst_id_i;
    ram_we    = 1'b0;
    ram_waddr = s1_id_q;
    ram_wdata = wr_val;
    if (state_q == CLR) begin
      ram_we    = clk_en;
      ram_waddr = idx_q;
      ram_wdata = '0;
    end else if (drain_hs) begin
      ram_we    = 1'b1;
      ram_waddr = idx_q;
      ram_wdata = '0;
    end else if (s1_valid_q) begin
      ram_we    = clk_en;
    end
  end

  acc_ram_1r1w #(
    .Depth (N_NEURON),
    .Width (ACC_W),
    .AddrW (NEURON_ID_W)
  ) u_ram (
    .clk_i   (clk),
    .re_i    (ram_re),
    .raddr_i (ram_raddr),
    .rdata_o (ram_rdata),
    .we_i    (ram_we),
    .waddr_i (ram_waddr),
    .wdata_i (ram_wdata)
  );

  // Next-state logic for the clear / accumulate / flush / drain sequence.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    tick_pend_d = tick_pend_q;
    unique case (state_q)
      CLR: begin
        if (idx_q == LastId) begin
          state_d = ACC;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      ACC: begin
        if (tick_i) state_d = FLUSH;
      end
      FLUSH: begin
        if (tick_i) tick_pend_d = 1'b1;
        if (!s1_valid_q) begin
          state_d = DRAIN;
          idx_d   = '0;
        end
      end
      DRAIN: begin
        if (tick_i) tick_pend_d = 1'b1;
        if (drain_hs) begin
          if (out_last_q) begin
            idx_d = '0;
            if (tick_pend_q || tick_i) begin
              state_d     = FLUSH;
              tick_pend_d = 1'b0;
            end else begin
              state_d = ACC;
            end
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = CLR;
    endcase
  end

  // Control state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= CLR;
      idx_q       <= '0;
      tick_pend_q <= 1'b0;
    end else if (clk_en) begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      tick_pend_q <= tick_pend_d;
    end
  end

  // RMW pipeline registers and saturation counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_id_q    <= '0;
      s1_w_q     <= '0;
      s2_valid_q <= 1'b0;
      s2_id_q    <= '0;
      s2_val_q   <= '0;
      sat_cnt_q  <= '0;
    end else if (clk_en) begin
      s1_valid_q <= syn_accept;
      if (syn_accept) begin
        s1_id_q <= syn_dst_id_i;
        s1_w_q  <= syn_weight_i;
      end
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_id_q  <= s1_id_q;
        s2_val_q <= wr_val;
        if (wr_sat && (sat_cnt_q != 16'hFFFF)) sat_cnt_q <= sat_cnt_q + 16'd1;
      end
    end
  end

  // Drain output register: loads when read data returns, clears on handshake.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_pend_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_id_q    <= '0;
      out_cur_q   <= '0;
      out_last_q  <= 1'b0;
    end else if (clk_en) begin
      rd_pend_q <= drain_issue;
      if (rd_pend_q) begin
        out_valid_q <= 1'b1;
        out_id_q    <= idx_q;
        out_cur_q   <= ram_rdata;
        out_last_q  <= (idx_q == LastId);
      end else if (drain_hs) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign drain_valid_o = out_valid_q;
  assign drain_id_o    = out_id_q;
  assign drain_cur_o   = out_cur_q;
  assign drain_last_o  = out_last_q;
  assign busy_o        = (state_q != ACC);
  assign sat_cnt_o     = sat_cnt_q;

endmodule

// File: tb/tb_synaptic_current_accumulator.sv
// Directed bench: a scoreboard queue of expected drain beats, filled on tick, checked on handshake.
// Two instances run in lockstep: accumulate mode and overwrite mode.
module tb_synaptic_current_accumulator;

  localparam int N       = 64;
  localparam int ACC_MAX = 8388607;
  localparam int ACC_MIN = -8388608;

  logic        clk = 1'b0;
  logic        rst_n, clk_en, syn_in_valid, tick_i, drain_ready_i;
  logic [5:0]  syn_dst_id_i;
  logic [15:0] syn_weight_i;

  logic        syn_in_ready, drain_valid_o, drain_last_o, busy_o;
  logic [5:0]  drain_id_o;
  logic [23:0] drain_cur_o;
  logic [15:0] sat_cnt_o;

  logic        ow_ready, ow_valid, ow_last, ow_busy;
  logic [5:0]  ow_id;
  logic [23:0] ow_cur;
  logic [15:0] ow_sat;

  typedef struct packed {
    logic [5:0]  id;
    logic [23:0] cur;
    logic [23:0] cur_ow;
    logic        last;
  } exp_t;

  exp_t exp_q[$];
  int   model[N];
  int   model_ow[N];
  int   sat_exp;
  int   errors = 0;
  int   checks = 0;
  int   lat;

  always #5 clk = ~clk;

  synaptic_current_accumulator #(.ACCUMULATE_ON_COLLISION(1'b1)) u_dut (
    .clk (clk), .rst_n (rst_n), .clk_en (clk_en),
    .syn_in_valid (syn_in_valid), .syn_in_ready (syn_in_ready),
    .syn_dst_id_i (syn_dst_id_i), .syn_weight_i (syn_weight_i), .tick_i (tick_i),
    .drain_valid_o (drain_valid_o), .drain_ready_i (drain_ready_i),
    .drain_id_o (drain_id_o), .drain_cur_o (drain_cur_o), .drain_last_o (drain_last_o),
    .busy_o (busy_o), .sat_cnt_o (sat_cnt_o)
  );

  synaptic_current_accumulator #(.ACCUMULATE_ON_COLLISION(1'b0)) u_dut_ow (
    .clk (clk), .rst_n (rst_n), .clk_en (clk_en),
    .syn_in_valid (syn_in_valid), .syn_in_ready (ow_ready),
    .syn_dst_id_i (syn_dst_id_i), .syn_weight_i (syn_weight_i), .tick_i (tick_i),
    .drain_valid_o (ow_valid), .drain_ready_i (drain_ready_i),
    .drain_id_o (ow_id), .drain_cur_o (ow_cur), .drain_last_o (ow_last),
    .busy_o (ow_busy), .sat_cnt_o (ow_sat)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_model();
    for (int i = 0; i < N; i++) begin
      model[i]    = 0;
      model_ow[i] = 0;
    end
  endtask

  // Queue one expected beat per neuron from the model, then zero the model.
  task automatic push_timestep();
    exp_t e;
    for (int i = 0; i < N; i++) begin
      e.id     = 6'(i);
      e.cur    = 24'(model[i]);
      e.cur_ow = 24'(model_ow[i]);
      e.last   = (i == N - 1);
      exp_q.push_back(e);
    end
    clear_model();
  endtask

  task automatic send_event(input int id, input int w);
    bit done;
    int s;
    done         = 1'b0;
    syn_in_valid = 1'b1;
    syn_dst_id_i = 6'(id);
    syn_weight_i = 16'(w);
    for (int k = 0; k < 200 && !done; k++) begin
      if (syn_in_ready) begin
        s = model[id] + w;
        if (s > ACC_MAX) begin
          s = ACC_MAX;
          sat_exp++;
        end else if (s < ACC_MIN) begin
          s = ACC_MIN;
          sat_exp++;
        end
        model[id]    = s;
        model_ow[id] = w;
        done         = 1'b1;
      end
      step();
    end
    syn_in_valid = 1'b0;
    if (!done) chk("event_accept_timeout", 64'(done), 64'd1);
  endtask

  task automatic do_tick();
    push_timestep();
    tick_i = 1'b1;
    step();
    tick_i = 1'b0;
  endtask

  task automatic wait_clear();
    repeat (63) step();
    chk("clr_busy_high", 64'(busy_o), 64'd1);
    step();
    chk("clr_busy_low", 64'(busy_o), 64'd0);
    chk("acc_ready", 64'(syn_in_ready), 64'd1);
  endtask

  // Consume n_exp drain beats; optional random ready/clk_en and a tick after tick_at beats.
  task automatic run_drain(input int n_exp, input bit rnd, input int tick_at,
                           output int first_lat);
    int          got, cyc;
    bit          hold;
    logic [5:0]  p_id;
    logic [23:0] p_cur;
    logic        p_last;
    exp_t        e;
    got       = 0;
    cyc       = 0;
    hold      = 1'b0;
    first_lat = -1;
    while (got < n_exp && cyc < 5000) begin
      if (rnd) begin
        drain_ready_i = 1'($urandom_range(0, 1));
        clk_en        = ($urandom_range(0, 3) != 0);
      end else begin
        drain_ready_i = 1'b1;
        clk_en        = 1'b1;
      end
      if (hold) begin
        chk("stall_valid", 64'(drain_valid_o), 64'd1);
        chk("stall_id", 64'(drain_id_o), 64'(p_id));
        chk("stall_cur", 64'(drain_cur_o), 64'(p_cur));
        chk("stall_last", 64'(drain_last_o), 64'(p_last));
      end
      if (!clk_en) chk("clk_en_low_no_ready", 64'(syn_in_ready), 64'd0);
      if (drain_valid_o && first_lat < 0) first_lat = cyc;
      if (drain_valid_o && drain_ready_i && clk_en) begin
        chk("sb_nonempty", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("drain_id", 64'(drain_id_o), 64'(e.id));
          chk("drain_cur", 64'(drain_cur_o), 64'(e.cur));
          chk("drain_last", 64'(drain_last_o), 64'(e.last));
          chk("ow_valid", 64'(ow_valid), 64'd1);
          chk("ow_id", 64'(ow_id), 64'(e.id));
          chk("ow_cur", 64'(ow_cur), 64'(e.cur_ow));
        end
        got++;
        if (got == tick_at) begin
          push_timestep();
          tick_i = 1'b1;
        end
      end
      hold   = drain_valid_o && !(drain_ready_i && clk_en);
      p_id   = drain_id_o;
      p_cur  = drain_cur_o;
      p_last = drain_last_o;
      step();
      tick_i = 1'b0;
      cyc++;
    end
    drain_ready_i = 1'b1;
    clk_en        = 1'b1;
    chk("drain_beats", 64'(got), 64'(n_exp));
  endtask

  initial begin
    rst_n         = 1'b0;
    clk_en        = 1'b1;
    syn_in_valid  = 1'b0;
    syn_dst_id_i  = '0;
    syn_weight_i  = '0;
    tick_i        = 1'b0;
    drain_ready_i = 1'b1;
    sat_exp       = 0;
    clear_model();
    repeat (3) step();

    // Reset state
    chk("rst_valid", 64'(drain_valid_o), 64'd0);
    chk("rst_ready", 64'(syn_in_ready), 64'd0);
    chk("rst_busy", 64'(busy_o), 64'd1);
    chk("rst_sat", 64'(sat_cnt_o), 64'd0);
    chk("rst_id", 64'(drain_id_o), 64'd0);
    chk("rst_cur", 64'(drain_cur_o), 64'd0);
    chk("rst_last", 64'(drain_last_o), 64'd0);

    rst_n = 1'b1;
    wait_clear();

    // Empty timestep: 64 zero beats, first beat 3 cycles after FLUSH is entered
    do_tick();
    run_drain(64, 1'b0, -1, lat);
    chk("first_drain_latency", 64'(lat), 64'd3);
    chk("idle_after_drain", 64'(busy_o), 64'd0);

    // Back-to-back same-destination events rely on forwarding
    send_event(5, 100);
    send_event(5, -30);
    send_event(5, 7);
    do_tick();
    run_drain(64, 1'b0, -1, lat);

    // Positive then negative saturation
    for (int i = 0; i < 300; i++) send_event(9, 32767);
    do_tick();
    run_drain(64, 1'b0, -1, lat);
    chk("sat_cnt_pos", 64'(sat_cnt_o), 64'(sat_exp));
    chk("sat_cnt_nonzero", 64'(sat_cnt_o != 16'd0), 64'd1);
    for (int i = 0; i < 300; i++) send_event(9, -32768);
    do_tick();
    run_drain(64, 1'b0, -1, lat);
    chk("sat_cnt_neg", 64'(sat_cnt_o), 64'(sat_exp));
    chk("ow_sat_cnt", 64'(ow_sat), 64'd0);

    // Random traffic, random backpressure and clk_en, tick mid-drain adds a zero timestep
    for (int i = 0; i < 40; i++) begin
      send_event(int'($urandom_range(0, 63)), int'($urandom_range(0, 2000)) - 1000);
    end
    do_tick();
    run_drain(128, 1'b1, 30, lat);

    // Collision semantics: add vs overwrite
    send_event(3, 10);
    send_event(3, 20);
    do_tick();
    run_drain(64, 1'b0, -1, lat);

    // Reset in the middle of a drain
    send_event(20, 55);
    do_tick();
    run_drain(20, 1'b0, -1, lat);
    rst_n = 1'b0;
    step();
    chk("midrst_valid", 64'(drain_valid_o), 64'd0);
    chk("midrst_busy", 64'(busy_o), 64'd1);
    chk("midrst_sat", 64'(sat_cnt_o), 64'd0);
    rst_n = 1'b1;
    exp_q.delete();
    clear_model();
    sat_exp = 0;
    wait_clear();
    do_tick();
    run_drain(64, 1'b0, -1, lat);
    chk("sb_drained", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
